nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//  Sequential WIDTH-bit adder that drives one 4-bit ripple-carry slice once per clock, one nibble at a time, LSB nibble first.
//  Sits directly upstream of, and owns, the 4-bit adder datapath. It registers wide operands, sequences them through the slice,
//  chains the carry, and returns the assembled sum over a valid/ready handshake. It trades latency for a single small adder.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; must be a multiple of 4 and >= 4. A violation is a compile-time error.
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst_n      in   1      reset; asynchronous assert, active-low
//  in_valid   in   1      operands a, b, cin are valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A, unsigned or two's complement
//  b          in   WIDTH  operand B
//  cin        in   1      carry into nibble 0
//  out_valid  out  1      sum/cout hold a completed result
//  out_ready  in   1      consumer accepts the result
//  sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//  - One clock (clk); reset rst_n is asynchronous and active-low. Reset forces state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0,
//    nibble counter=0, carry reg=0 (and ovf=0 when enabled).
//  - NIB = WIDTH/4. FSM states: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. When in_valid&&in_ready on edge E: capture a, b, cin into operand/carry regs, set counter=0, go to RUN.
//    in_valid while not in IDLE is ignored; no input is ever lost, because the source holds until handshake.
//  - RUN: each cycle, the slice adds a_reg[4i+3:4i] + b_reg[4i+3:4i] + carry. The result nibble goes into the working reg,
//    the slice carry-out goes into the carry reg, and i increments. After nibble NIB-1 (edge E+NIB): copy the working reg to sum,
//    copy the final carry to cout, and go to DONE.
//  - Latency: out_valid rises NIB cycles after the accepting edge (4 cycles at WIDTH=16). Throughput: one op per NIB+2 cycles
//    when out_ready is held high.
//  - DONE: out_valid=1. sum/cout stay stable until out_valid&&out_ready. On that edge: out_valid=0, go to IDLE,
//    and in_ready=1 from the next cycle. No accept and no output handshake can happen in the same cycle.
//  - sum/cout keep the last result after the handshake and change only on the next DONE entry.
//    The working reg is never visible on the outputs.
//  - Carry chain: the nibble-0 carry-in is cin. Each later nibble uses the previous slice carry-out. Wrap-around is modulo 2^WIDTH,
//    with the lost bit reported on cout.
//  - Reset mid-RUN or mid-DONE: the result is discarded and the block returns to the IDLE reset values asynchronously.
//    No partial result is ever presented.
//  - WIDTH=4: NIB=1, so RUN lasts exactly one cycle.
// CONFIGURATION
//  - Macro NIBBLE_SERIAL_ADDER_OVF_EN.
//  - Defined: adds output port ovf (1 bit), the two's-complement overflow (carry into bit WIDTH-1 XOR carry out of bit WIDTH-1).
//    It is registered with sum/cout on DONE entry, reset to 0, and held stable the same way as sum.
//  - Undefined: the port and its logic are absent, and every other behaviour is identical.
// STRUCTURE
//  - Shared package nibble_adder_pkg: NIB_W=4 constant and the FSM state encoding (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2).
//  - One sub-module: nibble_add (4-bit ripple carry of full adders; ports a[3:0], b[3:0], ci -> s[3:0], co), purely combinational.
//    The slice must expose the carry into bit 3 (c3) for the OVF_EN overflow term.
//  - The top holds the FSM, a $clog2(NIB)-bit counter, the operand regs, the carry reg and the working/sum regs.
// TESTING (WIDTH=16 unless noted)
//  1. a=0x0001, b=0x0001, cin=0 -> sum=0x0002, cout=0. out_valid rises exactly 4 cycles after the accept edge.
//  2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. The carry ripples through all 4 nibbles.
//  3. a=0x9B0F, b=0x5DF1, cin=1 -> sum=0xF901, cout=0. Hold out_ready=0 for 5 cycles: sum stays stable and in_ready stays 0.
//     A concurrent in_valid is ignored.
//  4. Start a=0x1234, b=0x1111; assert rst_n=0 after 2 RUN cycles -> out_valid=0, sum=0, in_ready=1 immediately.
//     After release, 0x0003+0x0004 -> sum=0x0007.
//  5. NIBBLE_SERIAL_ADDER_OVF_EN, a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
//     a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
//  6. WIDTH=4, back-to-back ops with out_ready=1: 0xF+0x1 -> sum=0x0, cout=1, then 0x9+0x5 -> sum=0xE.
//     Each op takes 3 cycles from accept to the next accept.

Source files
------------

// File: rtl/nibble_adder_pkg.sv
// rtl/nibble_adder_pkg.sv - slice width and FSM state encoding shared by the nibble serial adder
package nibble_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add.sv
// rtl/nibble_add.sv - combinational 4-bit ripple-carry slice of full adders
// c3 is the carry into the top bit, used by the overflow term.
module nibble_add
  import nibble_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co,
  output logic             c3
);

  logic [NIB_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[NIB_W];
  assign c3 = c[NIB_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder sequenced one nibble per clock through a single slice
// Optional NIBBLE_SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  if (WIDTH < NIB_W || (WIDTH % NIB_W) != 0) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   work_next;
  logic               carry;
  logic [NIB_W-1:0]   sl_a;
  logic [NIB_W-1:0]   sl_b;
  logic [NIB_W-1:0]   sl_s;
  logic               sl_co;
  logic               sl_c3;
  logic               last;

  assign sl_a = a_reg[int'(cnt)*NIB_W +: NIB_W];
  assign sl_b = b_reg[int'(cnt)*NIB_W +: NIB_W];
  assign last = (cnt == CNT_W'(NIB - 1));

  nibble_add u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co),
    .c3 (sl_c3)
  );

`ifndef NIBBLE_SERIAL_ADDER_OVF_EN
  logic unused_c3;
  assign unused_c3 = sl_c3;
`endif

  // The final nibble is merged here so sum can load in the same edge it is computed.
  always_comb begin
    work_next = work;
    work_next[int'(cnt)*NIB_W +: NIB_W] = sl_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      work      <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b;
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          work  <= work_next;
          carry <= sl_co;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum       <= work_next;
            cout      <= sl_co;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf       <= sl_c3 ^ sl_co;
`endif
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - randomized self-checking bench for nibble_serial_adder (WIDTH=16 and WIDTH=4)
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;

  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        cin4 = 1'b0;
  logic        out_valid4;
  logic        out_ready4 = 1'b1;
  logic [3:0]  sum4;
  logic        cout4;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic        ovf;
  logic        ovf4;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_q[$];
  logic [4:0] res_q[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .cout      (cout4)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf4)
`endif
  );

  always @(posedge clk) begin
    cyc++;
    if (in_valid4 && in_ready4) acc_q.push_back(cyc);
    if (out_valid4 && out_ready4) res_q.push_back({cout4, sum4});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 17-bit arithmetic; overflow from operand/result sign bits.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input int hold);
    int n;
    logic [16:0] full;
    logic exp_ovf;
    full    = {1'b0, ta} + {1'b0, tb} + {16'd0, tc};
    exp_ovf = (ta[15] == tb[15]) && (full[15] != ta[15]);
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("in_ready_idle", in_ready, 1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    check("in_ready_busy", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("latency", n, 4);
    check("sum", sum, full[15:0]);
    check("cout", cout, full[16]);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check("ovf", ovf, exp_ovf);
`else
    if (exp_ovf) n = n;
`endif
    in_valid = (hold > 0);
    for (int k = 0; k < hold; k++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_sum", sum, full[15:0]);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_sum_kept", sum, full[15:0]);
  endtask

  initial begin
    int n;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    tick();

    do_op(16'h0001, 16'h0001, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(16'h9B0F, 16'h5DF1, 1'b1, 5);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 1);

    // Reset two RUN cycles into an op: outputs must drop without waiting for a clock.
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst_no_partial", out_valid, 0);
    end
    rst_n = 1'b1;
    tick();
    do_op(16'h0003, 16'h0004, 1'b0, 0);

    for (int k = 0; k < 24; k++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    // WIDTH=4 back-to-back with out_ready held high.
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; in_valid4 = 1'b1;
    n = 0;
    while (acc_q.size() < 1 && n < 20) begin tick(); n++; end
    a4 = 4'h9; b4 = 4'h5;
    n = 0;
    while (acc_q.size() < 2 && n < 20) begin tick(); n++; end
    in_valid4 = 1'b0;
    n = 0;
    while (res_q.size() < 2 && n < 20) begin tick(); n++; end
    check("w4_accepts", acc_q.size(), 2);
    check("w4_results", res_q.size(), 2);
    if (acc_q.size() == 2) check("w4_throughput", acc_q[1] - acc_q[0], 3);
    if (res_q.size() == 2) begin
      check("w4_res0", res_q[0], {1'b1, 4'h0});
      check("w4_res1", res_q[1], {1'b0, 4'hE});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
